run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Run-control block for the pipelined RV32I core. It watches the core's ECALL/EBREAK pulses and its MEM-stage PC, and decides when to halt the core: on an environment call, a breakpoint, a stuck-PC watchdog or a cycle-limit timeout.
- After halting, it freezes the pipeline and walks the register file read port to stream out all 32 architectural registers over a valid/ready channel.
- It sits beside `top`, between the core and the host/bench or debug UART.

Parameters:
- WDOG_LIMIT, 2000000, number of consecutive repeat cycles of mem_pc that trips the watchdog.
- MAX_CYCLES, 50000000, RUN cycle count that trips the timeout; 0 disables the timeout.
- CYC_W, 64, width of the cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ecall_pulse  in  1  one-cycle ECALL indication from the core
- ebreak_pulse  in  1  one-cycle EBREAK indication from the core
- mem_pc  in  32  MEM-stage PC of the core
- core_halt  out  1  freeze request to the core; holds all pipeline registers, no regfile writes
- rf_raddr  out  5  regfile debug read address
- rf_rdata  in  32  regfile debug read data; asynchronous read of rf_raddr
- dump_valid  out  1  dump word available
- dump_ready  in  1  consumer accepts the dump word
- dump_idx  out  5  register index of dump_data
- dump_data  out  32  register value
- halted  out  1  halt event has occurred; stays high until reset
- dump_done  out  1  all 32 words have been accepted; stays high until reset
- halt_cause  out  3  0=none, 1=ecall, 2=ebreak, 3=watchdog, 4=timeout
- cycle_count  out  CYC_W  RUN cycles elapsed before the halt event

Behaviour:
- Reset (asynchronous, any state):
  - State goes to RUN.
  - All outputs go to 0, including cycle_count, halt_cause, dump_idx and dump_data.
  - The internal stuck_pc register goes to 32'hFFFFFFFF and stuck_cnt goes to 0.
- States: RUN, DUMP_RD, DUMP_OUT, DONE.
- RUN, watchdog tracking:
  - Each cycle, if mem_pc == stuck_pc, stuck_cnt increments.
  - Otherwise stuck_pc is loaded with mem_pc and stuck_cnt is cleared.
  - The watchdog event is the condition stuck_cnt == WDOG_LIMIT.
- RUN, timeout event: the condition cycle_count == MAX_CYCLES with MAX_CYCLES != 0.
- RUN, halt event handling:
  - A halt event is ecall_pulse, ebreak_pulse, watchdog or timeout.
  - On a halt event, halt_cause is latched using priority ecall > ebreak > watchdog > timeout.
  - In the same cycle, halted is set, cycle_count is not incremented, and the state moves to DUMP_RD.
  - core_halt is registered and goes high on the cycle after the event.
  - With no event, cycle_count increments by 1 and saturates at all-ones.
- cycle_count value at halt: an event in the N-th RUN cycle after reset leaves cycle_count = N-1.
- DUMP_RD (one cycle):
  - rf_raddr = dump_idx and dump_valid = 0.
  - dump_data captures rf_rdata at the clock edge; the state moves to DUMP_OUT.
- DUMP_OUT:
  - dump_valid = 1; dump_data and dump_idx are held stable while dump_ready = 0.
  - On dump_valid & dump_ready:
    - If dump_idx == 31, go to DONE.
    - Otherwise increment dump_idx and go to DUMP_RD.
  - Throughput is one word per 2 cycles at best.
- Dump content: x0 is dumped as read, so 0 from a correct regfile. Exactly 32 words are sent, index 0..31 in order, with no repeats or skips.
- DONE:
  - dump_done = 1, dump_valid = 0, core_halt = 1, halted = 1.
  - halt_cause and cycle_count are frozen.
  - dump_idx and dump_data keep their last values (31 and the x31 word).
- After the halt event (DUMP_RD, DUMP_OUT and DONE):
  - ecall_pulse, ebreak_pulse and mem_pc are ignored.
  - The watchdog and timeout logic is frozen.
- rf_raddr is 0 in RUN and DONE.
- Reset mid-dump:
  - The dump is aborted immediately; all outputs return to reset values.
  - The core resumes when rst deasserts.

Test Plan:
- ecall_pulse in the 11th RUN cycle, mem_pc incrementing, dump_ready tied 1 → halt_cause=1, cycle_count=10, core_halt high from the next cycle, 32 words idx 0..31 with dump_data = regfile contents, dump_done after the idx 31 handshake.
- ecall_pulse and ebreak_pulse asserted in the same cycle → halt_cause=1. In a second run with ebreak_pulse alone → halt_cause=2.
- WDOG_LIMIT=8, mem_pc held at 32'h00000100 from the first cycle → stuck_cnt 1..8 over the following cycles; halt_cause=3 on the 9th cycle after mem_pc is loaded into stuck_pc.
- MAX_CYCLES=20, mem_pc toggling, no pulses → halt_cause=4, cycle_count=20. A run with MAX_CYCLES=0 never halts within 1000 cycles.
- Backpressure: dump_ready=0 for 5 cycles while dump_idx=3 → dump_valid stays 1 and dump_idx/dump_data stay stable; dump_ready=1 then advances to idx 4.
- Reset asserted while dump_idx=12, then later pulses in DONE:
  - Reset → all outputs 0 and state RUN; a fresh ebreak then gives a complete dump from idx 0.
  - ecall_pulse asserted in DONE → halt_cause and cycle_count unchanged.

Source files
------------

// File: rtl/run_ctrl_if.sv
// Register-dump stream leaving run_ctrl: one architectural register word per valid/ready handshake.
interface run_ctrl_if;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;

    modport master (
        output dump_valid,
        output dump_idx,
        output dump_data,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_idx,
        input  dump_data,
        output dump_ready
    );
endinterface

// File: rtl/run_ctrl.sv
// Run control for the RV32I core: halts on ECALL/EBREAK, stuck-PC watchdog or cycle timeout,
// then freezes the core and streams all 32 registers out over the dump channel.
module run_ctrl #(
    parameter int unsigned WDOG_LIMIT = 2000000,
    parameter int unsigned MAX_CYCLES = 50000000,
    parameter int unsigned CYC_W      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ecall_pulse,
    input  logic             ebreak_pulse,
    input  logic [31:0]      mem_pc,
    output logic             core_halt,
    output logic [4:0]       rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic             halted,
    output logic             dump_done,
    output logic [2:0]       halt_cause,
    output logic [CYC_W-1:0] cycle_count,
    run_ctrl_if.master       dump
);

    typedef enum logic [1:0] {
        RUN,
        DUMP_RD,
        DUMP_OUT,
        DONE
    } state_t;

    localparam logic [2:0]       CAUSE_ECALL   = 3'd1;
    localparam logic [2:0]       CAUSE_EBREAK  = 3'd2;
    localparam logic [2:0]       CAUSE_WDOG    = 3'd3;
    localparam logic [2:0]       CAUSE_TIMEOUT = 3'd4;
    localparam logic [31:0]      WDOG_CNT      = 32'(WDOG_LIMIT);
    localparam logic [CYC_W-1:0] CYC_LIMIT     = CYC_W'(MAX_CYCLES);
    localparam bit               TMO_EN        = (MAX_CYCLES != 0);

    state_t      state;
    logic [31:0] stuck_pc;
    logic [31:0] stuck_cnt;
    logic        wdog_hit;
    logic        tmo_hit;
    logic        halt_evt;
    logic [2:0]  next_cause;

    // Halt event detection and cause priority: ecall > ebreak > watchdog > timeout.
    always_comb begin
        wdog_hit   = (stuck_cnt == WDOG_CNT);
        tmo_hit    = TMO_EN && (cycle_count == CYC_LIMIT);
        halt_evt   = ecall_pulse | ebreak_pulse | wdog_hit | tmo_hit;
        next_cause = 3'd0;
        if (ecall_pulse) begin
            next_cause = CAUSE_ECALL;
        end else if (ebreak_pulse) begin
            next_cause = CAUSE_EBREAK;
        end else if (wdog_hit) begin
            next_cause = CAUSE_WDOG;
        end else if (tmo_hit) begin
            next_cause = CAUSE_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            core_halt      <= 1'b0;
            rf_raddr       <= 5'd0;
            halted         <= 1'b0;
            dump_done      <= 1'b0;
            halt_cause     <= 3'd0;
            cycle_count    <= '0;
            stuck_pc       <= 32'hFFFF_FFFF;
            stuck_cnt      <= 32'd0;
            dump.dump_valid <= 1'b0;
            dump.dump_idx   <= 5'd0;
            dump.dump_data  <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_evt) begin
                        halt_cause <= next_cause;
                        halted     <= 1'b1;
                        core_halt  <= 1'b1;
                        state      <= DUMP_RD;
                    end else begin
                        if (cycle_count != '1) begin
                            cycle_count <= cycle_count + CYC_W'(1);
                        end
                        if (mem_pc == stuck_pc) begin
                            stuck_cnt <= stuck_cnt + 32'd1;
                        end else begin
                            stuck_pc  <= mem_pc;
                            stuck_cnt <= 32'd0;
                        end
                    end
                end

                // rf_raddr already points at dump_idx on entry; capture the asynchronous read.
                DUMP_RD: begin
                    dump.dump_data  <= rf_rdata;
                    dump.dump_valid <= 1'b1;
                    rf_raddr        <= 5'd0;
                    state           <= DUMP_OUT;
                end

                DUMP_OUT: begin
                    if (dump.dump_ready) begin
                        dump.dump_valid <= 1'b0;
                        if (dump.dump_idx == 5'd31) begin
                            dump_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            dump.dump_idx <= dump.dump_idx + 5'd1;
                            rf_raddr      <= dump.dump_idx + 5'd1;
                            state         <= DUMP_RD;
                        end
                    end
                end

                DONE: begin
                    state <= DONE;
                end

                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: random stimulus scored against a cycle-indexed halt model
// and a regfile image that the dump stream must reproduce word for word.
module tb_run_ctrl;

    localparam int W       = 8;
    localparam int M       = 20;
    localparam int MAX_LEN = 1100;

    logic        clk = 1'b0;
    logic        rst;
    logic        ecall_pulse;
    logic        ebreak_pulse;
    logic [31:0] mem_pc;

    logic        core_halt;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        halted;
    logic        dump_done;
    logic [2:0]  halt_cause;
    logic [63:0] cycle_count;

    logic        core_halt_b;
    logic [4:0]  rf_raddr_b;
    logic [31:0] rf_rdata_b;
    logic        halted_b;
    logic        dump_done_b;
    logic [2:0]  halt_cause_b;
    logic [63:0] cycle_count_b;

    logic [31:0] regs [32];
    logic [31:0] pc_seq [1:MAX_LEN];
    bit          ec_seq [1:MAX_LEN];
    bit          eb_seq [1:MAX_LEN];
    logic [4:0]  obs_idx [32];
    logic [31:0] obs_data [32];

    int total = 0;
    int bad   = 0;

    run_ctrl_if dump_a ();
    run_ctrl_if dump_b ();

    assign rf_rdata          = regs[rf_raddr];
    assign rf_rdata_b        = regs[rf_raddr_b];
    assign dump_b.dump_ready = 1'b1;

    always #5 clk = ~clk;

    run_ctrl #(.WDOG_LIMIT(W), .MAX_CYCLES(M), .CYC_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .ecall_pulse  (ecall_pulse),
        .ebreak_pulse (ebreak_pulse),
        .mem_pc       (mem_pc),
        .core_halt    (core_halt),
        .rf_raddr     (rf_raddr),
        .rf_rdata     (rf_rdata),
        .halted       (halted),
        .dump_done    (dump_done),
        .halt_cause   (halt_cause),
        .cycle_count  (cycle_count),
        .dump         (dump_a)
    );

    run_ctrl #(.WDOG_LIMIT(W), .MAX_CYCLES(0), .CYC_W(64)) dut_nt (
        .clk          (clk),
        .rst          (rst),
        .ecall_pulse  (ecall_pulse),
        .ebreak_pulse (ebreak_pulse),
        .mem_pc       (mem_pc),
        .core_halt    (core_halt_b),
        .rf_raddr     (rf_raddr_b),
        .rf_rdata     (rf_rdata_b),
        .halted       (halted_b),
        .dump_done    (dump_done_b),
        .halt_cause   (halt_cause_b),
        .cycle_count  (cycle_count_b),
        .dump         (dump_b)
    );

    // Reference: first cycle n whose rules fire. A watchdog trip needs W+1 identical PCs
    // ending in the previous cycle (first one loads, then W repeats).
    function automatic void model_halt(input int len, input int mc,
                                       output int n_exp, output logic [2:0] c_exp);
        int rl;
        n_exp = 0;
        c_exp = 3'd0;
        for (int n = 1; n <= len; n++) begin
            rl = 0;
            if (n > 1) begin
                rl = 1;
                while ((n - 1 - rl >= 1) && (pc_seq[n-1-rl] == pc_seq[n-1])) rl++;
            end
            if (ec_seq[n])                        c_exp = 3'd1;
            else if (eb_seq[n])                   c_exp = 3'd2;
            else if (rl == W + 1)                 c_exp = 3'd3;
            else if ((mc != 0) && (n - 1 == mc))  c_exp = 3'd4;
            if (c_exp != 3'd0) begin
                n_exp = n;
                return;
            end
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ecall_pulse = 1'b0;
        ebreak_pulse = 1'b0;
        mem_pc = 32'd0;
        dump_a.dump_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill_regs();
        regs[0] = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
    endtask

    task automatic clear_seq();
        for (int n = 1; n <= MAX_LEN; n++) begin
            pc_seq[n] = 32'h1000 + 32'(4 * n);
            ec_seq[n] = 1'b0;
            eb_seq[n] = 1'b0;
        end
    endtask

    // Plays pc/pulse tables one RUN cycle at a time and reports the cycle halted rose.
    task automatic run_until_halt(input int len, output int n_obs, output logic [2:0] c_obs,
                                  output logic [63:0] cc_obs, output int early);
        n_obs = 0;
        early = 0;
        for (int n = 1; n <= len && n_obs == 0; n++) begin
            mem_pc = pc_seq[n];
            ecall_pulse = ec_seq[n];
            ebreak_pulse = eb_seq[n];
            @(posedge clk);
            #1;
            ecall_pulse = 1'b0;
            ebreak_pulse = 1'b0;
            if (halted) n_obs = n;
            else if (core_halt) early++;
        end
        c_obs = halt_cause;
        cc_obs = cycle_count;
    endtask

    task automatic collect_dump(input bit rnd, output int cnt, output int unstable, output int hung);
        bit          rdy;
        bit          hold;
        logic [4:0]  pidx;
        logic [31:0] pdata;
        cnt = 0;
        unstable = 0;
        hung = 1;
        hold = 1'b0;
        pidx = 5'd0;
        pdata = 32'd0;
        for (int i = 0; i < 32; i++) begin
            obs_idx[i] = 'x;
            obs_data[i] = 'x;
        end
        for (int c = 0; c < 400; c++) begin
            if (dump_done) begin
                hung = 0;
                break;
            end
            if (hold && (!dump_a.dump_valid || dump_a.dump_idx !== pidx || dump_a.dump_data !== pdata))
                unstable++;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            dump_a.dump_ready = rdy;
            if (dump_a.dump_valid && rdy) begin
                if (cnt < 32) begin
                    obs_idx[cnt] = dump_a.dump_idx;
                    obs_data[cnt] = dump_a.dump_data;
                end
                cnt++;
            end
            hold = dump_a.dump_valid && !rdy;
            pidx = dump_a.dump_idx;
            pdata = dump_a.dump_data;
            @(posedge clk);
            #1;
        end
        dump_a.dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ecall_pulse = 1'b0;
        ebreak_pulse = 1'b0;
        mem_pc = 32'd0;
        dump_a.dump_ready = 1'b0;
        #1;
        total++;
        if ({core_halt, halted, dump_done, halt_cause, cycle_count, rf_raddr,
             dump_a.dump_valid, dump_a.dump_idx, dump_a.dump_data} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got halted=%b cause=%0d cc=%0d valid=%b idx=%0d want all 0",
                     halted, halt_cause, cycle_count, dump_a.dump_valid, dump_a.dump_idx);
        end
        total++;
        if ({core_halt_b, halted_b, dump_done_b, halt_cause_b, cycle_count_b} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs_b: got halted=%b cc=%0d want all 0", halted_b, cycle_count_b);
        end
    endtask

    task automatic test_ecall();
        int n_exp, n_obs, early, cnt, unstable, hung, wrong;
        logic [2:0] c_exp, c_obs;
        logic [63:0] cc_obs;
        do_reset();
        fill_regs();
        clear_seq();
        ec_seq[11] = 1'b1;
        model_halt(40, M, n_exp, c_exp);
        run_until_halt(40, n_obs, c_obs, cc_obs, early);
        total++;
        if (n_obs != n_exp) begin bad++; $display("[TB] FAIL ecall_cycle: got %0d want %0d", n_obs, n_exp); end
        total++;
        if (c_obs !== c_exp) begin bad++; $display("[TB] FAIL ecall_cause: got %0d want %0d", c_obs, c_exp); end
        total++;
        if (cc_obs !== 64'(n_exp - 1)) begin bad++; $display("[TB] FAIL ecall_cc: got %0d want %0d", cc_obs, n_exp - 1); end
        total++;
        if (core_halt !== 1'b1 || early != 0) begin
            bad++;
            $display("[TB] FAIL ecall_core_halt: got %b early=%0d want 1 early=0", core_halt, early);
        end
        collect_dump(1'b0, cnt, unstable, hung);
        total++;
        if (cnt != 32 || hung != 0) begin bad++; $display("[TB] FAIL ecall_dump_count: got %0d hung=%0d want 32 hung=0", cnt, hung); end
        wrong = 0;
        for (int i = 0; i < 32; i++)
            if (obs_idx[i] !== 5'(i) || obs_data[i] !== regs[i]) wrong++;
        total++;
        if (wrong != 0) begin bad++; $display("[TB] FAIL ecall_dump_words: got %0d wrong words want 0", wrong); end
        total++;
        if (dump_done !== 1'b1 || dump_a.dump_valid !== 1'b0 || rf_raddr !== 5'd0) begin
            bad++;
            $display("[TB] FAIL ecall_done: got done=%b valid=%b raddr=%0d want 1 0 0", dump_done, dump_a.dump_valid, rf_raddr);
        end
    endtask

    task automatic test_priority();
        int n_exp, n_obs, early, k;
        logic [2:0] c_exp, c_obs;
        logic [63:0] cc_obs;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            clear_seq();
            k = $urandom_range(1, 15);
            eb_seq[k] = 1'b1;
            if (pass == 0) ec_seq[k] = 1'b1;
            model_halt(40, M, n_exp, c_exp);
            run_until_halt(40, n_obs, c_obs, cc_obs, early);
            total++;
            if (c_obs !== c_exp || cc_obs !== 64'(n_exp - 1)) begin
                bad++;
                $display("[TB] FAIL priority_%0d: got cause=%0d cc=%0d want cause=%0d cc=%0d",
                         pass, c_obs, cc_obs, c_exp, n_exp - 1);
            end
        end
    endtask

    task automatic test_watchdog();
        int n_exp, n_obs, early;
        logic [2:0] c_exp, c_obs;
        logic [63:0] cc_obs;
        do_reset();
        clear_seq();
        for (int n = 1; n <= 40; n++) pc_seq[n] = 32'h0000_0100;
        model_halt(40, M, n_exp, c_exp);
        run_until_halt(40, n_obs, c_obs, cc_obs, early);
        total++;
        if (n_obs != n_exp || c_obs !== c_exp || cc_obs !== 64'(n_exp - 1)) begin
            bad++;
            $display("[TB] FAIL watchdog: got cycle=%0d cause=%0d cc=%0d want cycle=%0d cause=%0d cc=%0d",
                     n_obs, c_obs, cc_obs, n_exp, c_exp, n_exp - 1);
        end
    endtask

    task automatic test_timeout();
        int n_exp, n_obs, early;
        logic [2:0] c_exp, c_obs;
        logic [63:0] cc_obs;
        do_reset();
        clear_seq();
        for (int n = 1; n <= 40; n++) pc_seq[n] = (n % 2 == 0) ? 32'h300 : 32'h304;
        model_halt(40, M, n_exp, c_exp);
        run_until_halt(40, n_obs, c_obs, cc_obs, early);
        total++;
        if (n_obs != n_exp || c_obs !== c_exp || cc_obs !== 64'(M)) begin
            bad++;
            $display("[TB] FAIL timeout: got cycle=%0d cause=%0d cc=%0d want cycle=%0d cause=%0d cc=%0d",
                     n_obs, c_obs, cc_obs, n_exp, c_exp, M);
        end
    endtask

    task automatic test_no_timeout();
        int seen_halt;
        do_reset();
        seen_halt = 0;
        for (int n = 1; n <= 1000; n++) begin
            mem_pc = (n % 2 == 0) ? 32'h200 : 32'h204;
            @(posedge clk);
            #1;
            if (halted_b || core_halt_b) seen_halt++;
        end
        total++;
        if (seen_halt != 0 || cycle_count_b !== 64'd1000) begin
            bad++;
            $display("[TB] FAIL no_timeout: got halt_cycles=%0d cc=%0d want 0 1000", seen_halt, cycle_count_b);
        end
    endtask

    task automatic test_backpressure();
        int n_obs, early, guard, drift;
        logic [2:0] c_obs;
        logic [63:0] cc_obs;
        do_reset();
        fill_regs();
        clear_seq();
        eb_seq[3] = 1'b1;
        run_until_halt(20, n_obs, c_obs, cc_obs, early);
        guard = 0;
        while (!(dump_a.dump_valid && dump_a.dump_idx == 5'd3) && guard < 100) begin
            dump_a.dump_ready = 1'b1;
            @(posedge clk);
            #1;
            guard++;
        end
        dump_a.dump_ready = 1'b0;
        total++;
        if (guard >= 100) begin bad++; $display("[TB] FAIL bp_reach_idx3: got idx=%0d want 3", dump_a.dump_idx); end
        drift = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (dump_a.dump_valid !== 1'b1 || dump_a.dump_idx !== 5'd3 || dump_a.dump_data !== regs[3]) drift++;
        end
        total++;
        if (drift != 0) begin bad++; $display("[TB] FAIL bp_hold: got %0d unstable cycles want 0", drift); end
        dump_a.dump_ready = 1'b1;
        @(posedge clk);
        #1;
        dump_a.dump_ready = 1'b0;
        guard = 0;
        while (!dump_a.dump_valid && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (dump_a.dump_valid !== 1'b1 || dump_a.dump_idx !== 5'd4 || dump_a.dump_data !== regs[4]) begin
            bad++;
            $display("[TB] FAIL bp_advance: got valid=%b idx=%0d data=%h want 1 4 %h",
                     dump_a.dump_valid, dump_a.dump_idx, dump_a.dump_data, regs[4]);
        end
    endtask

    task automatic test_reset_mid_dump();
        int n_exp, n_obs, early, guard, cnt, unstable, hung, wrong;
        logic [2:0] c_exp, c_obs;
        logic [63:0] cc_obs;
        do_reset();
        fill_regs();
        clear_seq();
        ec_seq[$urandom_range(1, 15)] = 1'b1;
        run_until_halt(20, n_obs, c_obs, cc_obs, early);
        guard = 0;
        while (dump_a.dump_idx != 5'd12 && guard < 100) begin
            dump_a.dump_ready = 1'b1;
            @(posedge clk);
            #1;
            guard++;
        end
        dump_a.dump_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (guard >= 100 || {core_halt, halted, dump_done, halt_cause, cycle_count, rf_raddr,
             dump_a.dump_valid, dump_a.dump_idx, dump_a.dump_data} !== '0) begin
            bad++;
            $display("[TB] FAIL mid_dump_reset: got idx=%0d valid=%b halted=%b cc=%0d want all 0 (guard=%0d)",
                     dump_a.dump_idx, dump_a.dump_valid, halted, cycle_count, guard);
        end
        do_reset();
        fill_regs();
        clear_seq();
        eb_seq[$urandom_range(1, 10)] = 1'b1;
        model_halt(20, M, n_exp, c_exp);
        run_until_halt(20, n_obs, c_obs, cc_obs, early);
        total++;
        if (c_obs !== c_exp || cc_obs !== 64'(n_exp - 1)) begin
            bad++;
            $display("[TB] FAIL rerun_halt: got cause=%0d cc=%0d want %0d %0d", c_obs, cc_obs, c_exp, n_exp - 1);
        end
        collect_dump(1'b1, cnt, unstable, hung);
        wrong = 0;
        for (int i = 0; i < 32; i++)
            if (obs_idx[i] !== 5'(i) || obs_data[i] !== regs[i]) wrong++;
        total++;
        if (cnt != 32 || hung != 0 || unstable != 0 || wrong != 0) begin
            bad++;
            $display("[TB] FAIL rerun_dump: got cnt=%0d hung=%0d unstable=%0d wrong=%0d want 32 0 0 0",
                     cnt, hung, unstable, wrong);
        end
        ecall_pulse = 1'b1;
        ebreak_pulse = 1'b1;
        mem_pc = 32'h0000_0100;
        @(posedge clk);
        #1;
        ecall_pulse = 1'b0;
        ebreak_pulse = 1'b0;
        total++;
        if (halt_cause !== c_exp || cycle_count !== 64'(n_exp - 1) || dump_done !== 1'b1 ||
            core_halt !== 1'b1 || dump_a.dump_valid !== 1'b0 || dump_a.dump_idx !== 5'd31 ||
            dump_a.dump_data !== regs[31]) begin
            bad++;
            $display("[TB] FAIL done_frozen: got cause=%0d cc=%0d done=%b idx=%0d want %0d %0d 1 31",
                     halt_cause, cycle_count, dump_done, dump_a.dump_idx, c_exp, n_exp - 1);
        end
    endtask

    task automatic test_random_runs();
        int n_exp, n_obs, early, cnt, unstable, hung, wrong;
        int hold_at, hold_len, pulse_at, kind;
        logic [2:0] c_exp, c_obs;
        logic [63:0] cc_obs;
        logic [31:0] pc;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            fill_regs();
            clear_seq();
            pc = 32'h1000 + 32'(16 * $urandom_range(0, 255));
            hold_at = $urandom_range(1, 25);
            hold_len = $urandom_range(2, 12);
            pulse_at = $urandom_range(1, 30);
            kind = $urandom_range(0, 3);
            for (int n = 1; n <= 40; n++) begin
                pc_seq[n] = pc;
                if (!(n >= hold_at && n < hold_at + hold_len - 1)) pc = pc + 32'(4 * $urandom_range(1, 3));
            end
            if (kind == 1 || kind == 3) ec_seq[pulse_at] = 1'b1;
            if (kind == 2 || kind == 3) eb_seq[pulse_at] = 1'b1;
            model_halt(40, M, n_exp, c_exp);
            run_until_halt(40, n_obs, c_obs, cc_obs, early);
            total++;
            if (n_obs != n_exp || c_obs !== c_exp || cc_obs !== 64'(n_exp - 1) || early != 0) begin
                bad++;
                $display("[TB] FAIL random_halt_%0d: got cycle=%0d cause=%0d cc=%0d want %0d %0d %0d",
                         r, n_obs, c_obs, cc_obs, n_exp, c_exp, n_exp - 1);
            end
            collect_dump(1'b1, cnt, unstable, hung);
            wrong = 0;
            for (int i = 0; i < 32; i++)
                if (obs_idx[i] !== 5'(i) || obs_data[i] !== regs[i]) wrong++;
            total++;
            if (cnt != 32 || hung != 0 || unstable != 0 || wrong != 0) begin
                bad++;
                $display("[TB] FAIL random_dump_%0d: got cnt=%0d hung=%0d unstable=%0d wrong=%0d want 32 0 0 0",
                         r, cnt, hung, unstable, wrong);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_priority();
        test_watchdog();
        test_timeout();
        test_no_timeout();
        test_backpressure();
        test_reset_mid_dump();
        test_random_runs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
